mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory stage of the pipeline and the consumer of the EX/MEM barrier outputs.
- Decodes the M control bits, computes the branch decision, and runs loads and stores on a ready-handshaked data-memory bus.
- Holds the pipeline with a stall while an access is outstanding, and hands a clean result (or a bubble) to the MEM/WB barrier.

Parameters:
- TIMEOUT, 16, max cycles spent in ACCESS waiting for dmem_ready before aborting (must be >= 1).
- REG_W, 4, width of the destination register index.

Ports:
- step_clk  in  1  pipeline clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- m_in  in  3  [0]=branch, [1]=mem_read, [2]=mem_write
- wb_in  in  2  [0]=reg_write, [1]=mem_to_reg
- alu_result_in  in  32  effective address / ALU result
- alu_zero_in  in  1  ALU zero flag
- read_data2_in  in  32  store data
- funct3_in  in  3  access size/sign
- write_reg_in  in  REG_W  destination register
- branch_target_in  in  64  branch target
- dmem_req  out  1  access request
- dmem_we  out  1  1=store
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-aligned store data
- dmem_ready  in  1  access complete; rdata valid when sampled high
- dmem_rdata  in  32  read data word
- stall_out  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- pc_src_out  out  1  take branch
- branch_target_out  out  64  pass-through of branch_target_in
- mem_data_out  out  32  extended load data
- alu_result_out  out  32  pass-through
- write_reg_out  out  REG_W  pass-through
- wb_out  out  2  wb_in, forced 2'b00 (bubble) when stalled or faulted
- fault_out  out  1  misaligned or illegal access, or timeout abort, this cycle

Behaviour:
- FSM states: IDLE, ACCESS. Registered: state, latched addr/be/wdata/we/funct3/byte offset, timeout counter.
- mem_op = m_in[1] | m_in[2]; both bits set counts as illegal.
- Legal access:
  - Loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: funct3 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Misaligned access: halfword with addr[0]=1, or word with addr[1:0]!=0.
- IDLE, mem_op, legal and aligned:
  - stall_out=1, wb_out=00.
  - Latch request fields; next state ACCESS.
- IDLE, mem_op, illegal or misaligned:
  - Combinational fault_out=1, wb_out=00, no request, no stall.
  - Stay in IDLE.
- IDLE, no mem_op: all pass-throughs combinational, zero latency, stall_out=0.
- ACCESS, dmem_ready=0:
  - dmem_req=1 from the latched fields; stall_out=1, wb_out=00.
  - Counter increments.
- ACCESS, dmem_ready=1:
  - stall_out=0, wb_out=wb_in; mem_data_out = extension of dmem_rdata (combinational, sampled by MEM/WB on the same edge).
  - Next state IDLE; counter cleared.
  - The barriers advance on that edge, so the same op is never reissued.
- ACCESS, counter reaches TIMEOUT-1 with dmem_ready=0:
  - fault_out=1, stall_out=0, wb_out=00.
  - Next state IDLE; request dropped on the following cycle.
- Byte enables and store data:
  - SB: be=1<<off, wdata = byte replicated ×4.
  - SH: be=0011 (off=0) or 1100 (off=2), wdata = half replicated ×2.
  - SW: be=1111.
  - Loads: be=1111, we=0.
- Load extraction uses the latched off:
  - LB/LH: sign-extend the selected lane.
  - LBU/LHU: zero-extend the selected lane.
  - LW: whole word.
- mem_data_out is 0 whenever not completing a load.
- pc_src_out = m_in[0] & alu_zero_in, independent of FSM.
- Reset (async, any state):
  - state=IDLE, counter=0, latched fields=0.
  - dmem_req=0 immediately; stall_out=0, fault_out=0, mem_data_out=0.

Test Plan:
- LW addr 0x100, dmem_ready high on first ACCESS cycle → dmem_req exactly 1 cycle, stall_out high 1 cycle then low, mem_data_out=0xDEADBEEF, wb_out=wb_in on completion edge.
- LB addr 0x103, rdata 0x80FFFFFF → be=1111, mem_data_out=0xFFFFFF80; LBU same → 0x00000080.
- SH addr 0x102, data2 0x0000ABCD, ready after 3 wait cycles → dmem_be=1100, wdata=0xABCDABCD, stall_out high 4 cycles, single request.
- LW addr 0x101 → no dmem_req, fault_out=1, wb_out=00, stall_out=0, state stays IDLE.
- LW with dmem_ready never high, TIMEOUT=16 → stall_out high 16 cycles, fault_out pulses on the 16th, req drops next cycle.
- reset_n low mid-ACCESS → dmem_req and stall_out fall without a clock edge; after release, a new SW to 0x200 proceeds normally; branch with zero=1 gives pc_src_out=1.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage; decodes M bits, resolves branches and runs loads/stores on a ready-handshaked data bus.
// Ports: step_clk/reset_n (async active-low); m_in/wb_in control from EX/MEM; alu_result_in, alu_zero_in,
// read_data2_in, funct3_in, write_reg_in, branch_target_in operands; dmem_* data-memory bus;
// stall_out/pc_src_out/fault_out pipeline control; *_out results towards MEM/WB.
module mem_access_stage #(
    parameter int TIMEOUT = 16,
    parameter int REG_W   = 4
) (
    input  logic             step_clk,
    input  logic             reset_n,
    input  logic [2:0]       m_in,
    input  logic [1:0]       wb_in,
    input  logic [31:0]      alu_result_in,
    input  logic             alu_zero_in,
    input  logic [31:0]      read_data2_in,
    input  logic [2:0]       funct3_in,
    input  logic [REG_W-1:0] write_reg_in,
    input  logic [63:0]      branch_target_in,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [31:0]      dmem_addr,
    output logic [3:0]       dmem_be,
    output logic [31:0]      dmem_wdata,
    input  logic             dmem_ready,
    input  logic [31:0]      dmem_rdata,
    output logic             stall_out,
    output logic             pc_src_out,
    output logic [63:0]      branch_target_out,
    output logic [31:0]      mem_data_out,
    output logic [31:0]      alu_result_out,
    output logic [REG_W-1:0] write_reg_out,
    output logic [1:0]       wb_out,
    output logic             fault_out
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0] be_q, be_d;
    logic we_q, we_d;
    logic [2:0] f3_q, f3_d;
    logic [1:0] off_q, off_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic mem_op, is_ld, is_st, legal, misal, bad, start, access, tmo, done;
    logic [15:0] lane;
    logic [31:0] ld_data;
    assign mem_op = m_in[1] | m_in[2];
    assign is_ld  = m_in[1] & ~m_in[2];
    assign is_st  = m_in[2] & ~m_in[1];
    assign legal  = is_ld ? (funct3_in inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) :
                    is_st ? (funct3_in inside {3'b000, 3'b001, 3'b010}) : 1'b0;
    assign misal  = (funct3_in[1:0] == 2'b01 && alu_result_in[0]) ||
                    (funct3_in[1:0] == 2'b10 && alu_result_in[1:0] != 2'b00);
    assign bad    = mem_op & (~legal | misal);
    assign start  = (state_q == IDLE) & mem_op & ~bad;
    assign access = state_q == ACCESS;
    // Abort on the last permitted ACCESS cycle rather than one later, so at most TIMEOUT cycles are spent waiting.
    assign tmo    = access & ~dmem_ready & (cnt_q == CW'(TIMEOUT - 1));
    assign done   = access & dmem_ready;
    always_ff @(posedge step_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        if (start) begin
            state_d = ACCESS;
            cnt_d   = '0;
            addr_d  = {alu_result_in[31:2], 2'b00};
            off_d   = alu_result_in[1:0];
            we_d    = m_in[2];
            f3_d    = funct3_in;
            be_d    = !m_in[2]                ? 4'b1111 :
                      funct3_in[1:0] == 2'b00 ? 4'b0001 << alu_result_in[1:0] :
                      funct3_in[1:0] == 2'b01 ? (alu_result_in[1] ? 4'b1100 : 4'b0011) : 4'b1111;
            wdata_d = funct3_in[1:0] == 2'b00 ? {4{read_data2_in[7:0]}} :
                      funct3_in[1:0] == 2'b01 ? {2{read_data2_in[15:0]}} : read_data2_in;
        end else if (access) begin
            state_d = (dmem_ready | tmo) ? IDLE : ACCESS;
            cnt_d   = (dmem_ready | tmo) ? '0 : CW'(cnt_q + 1'b1);
        end
    end
    // Shift the addressed lane down to bit 0; only the low halfword is needed for sub-word loads.
    assign lane    = 16'(dmem_rdata >> {off_q, 3'b000});
    assign ld_data = f3_q[1] ? dmem_rdata :
                     f3_q[0] ? {{16{~f3_q[2] & lane[15]}}, lane} :
                               {{24{~f3_q[2] & lane[7]}}, lane[7:0]};
    always_comb begin
        dmem_req          = access;
        dmem_we           = we_q;
        dmem_addr         = addr_q;
        dmem_be           = be_q;
        dmem_wdata        = wdata_q;
        // Gating with reset_n keeps these quiet during reset even if EX/MEM still presents a memory op.
        stall_out         = reset_n & (start | (access & ~dmem_ready & ~tmo));
        fault_out         = reset_n & (((state_q == IDLE) & bad) | tmo);
        wb_out            = (stall_out | fault_out) ? 2'b00 : wb_in;
        mem_data_out      = (reset_n & done & ~we_q) ? ld_data : 32'h0;
        pc_src_out        = m_in[0] & alu_zero_in;
        branch_target_out = branch_target_in;
        alu_result_out    = alu_result_in;
        write_reg_out     = write_reg_in;
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed vector table plus multi-cycle sequences for mem_access_stage.
module tb_mem_access_stage;
    logic step_clk = 1'b0, reset_n = 1'b0;
    logic [2:0] m_in = '0, funct3_in = '0;
    logic [1:0] wb_in = '0;
    logic [31:0] alu_result_in = '0, read_data2_in = '0, dmem_rdata = '0;
    logic alu_zero_in = 1'b0, dmem_ready = 1'b0;
    logic [3:0] write_reg_in = 4'hA;
    logic [63:0] branch_target_in = 64'h0123_4567_89AB_CDEF;
    logic dmem_req, dmem_we, stall_out, pc_src_out, fault_out;
    logic [31:0] dmem_addr, dmem_wdata, mem_data_out, alu_result_out;
    logic [3:0] dmem_be, write_reg_out;
    logic [63:0] branch_target_out;
    logic [1:0] wb_out;
    int nvec = 0, nerr = 0;

    mem_access_stage #(.TIMEOUT(16), .REG_W(4)) dut (
        .step_clk(step_clk), .reset_n(reset_n), .m_in(m_in), .wb_in(wb_in),
        .alu_result_in(alu_result_in), .alu_zero_in(alu_zero_in), .read_data2_in(read_data2_in),
        .funct3_in(funct3_in), .write_reg_in(write_reg_in), .branch_target_in(branch_target_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .stall_out(stall_out), .pc_src_out(pc_src_out), .branch_target_out(branch_target_out),
        .mem_data_out(mem_data_out), .alu_result_out(alu_result_out), .write_reg_out(write_reg_out),
        .wb_out(wb_out), .fault_out(fault_out)
    );

    always #5 step_clk = ~step_clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  m;
        logic [1:0]  wb;
        logic [31:0] alu;
        logic        zero;
        logic [2:0]  f3;
        logic        e_stall;
        logic        e_fault;
        logic        e_pc;
        logic [1:0]  e_wb;
    } vec_t;
    vec_t tbl [10];

    task automatic run_op(input string nm, input logic [2:0] m, input logic [31:0] alu, input logic [31:0] rd2,
                          input logic [2:0] f3, input int waits, input logic [31:0] rdata,
                          input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wdata,
                          input logic [31:0] e_data);
        @(negedge step_clk);
        m_in = m; alu_result_in = alu; read_data2_in = rd2; funct3_in = f3; wb_in = 2'b10; dmem_ready = 1'b0;
        #2;
        chk({nm, " issue stall"}, stall_out, 1);
        chk({nm, " issue req"}, dmem_req, 0);
        chk({nm, " issue wb"}, wb_out, 2'b00);
        for (int i = 0; i < waits; i++) begin
            @(negedge step_clk); #2;
            chk({nm, " wait req"}, dmem_req, 1);
            chk({nm, " wait stall"}, stall_out, 1);
        end
        @(negedge step_clk);
        dmem_ready = 1'b1; dmem_rdata = rdata;
        #2;
        chk({nm, " req"}, dmem_req, 1);
        chk({nm, " we"}, dmem_we, m[2]);
        chk({nm, " addr"}, dmem_addr, e_addr);
        chk({nm, " be"}, dmem_be, e_be);
        if (m[2]) chk({nm, " wdata"}, dmem_wdata, e_wdata);
        chk({nm, " done stall"}, stall_out, 0);
        chk({nm, " data"}, mem_data_out, e_data);
        chk({nm, " done wb"}, wb_out, 2'b10);
        @(negedge step_clk);
        m_in = 3'b000; dmem_ready = 1'b0;
        #2;
        chk({nm, " req drop"}, dmem_req, 0);
        chk({nm, " idle stall"}, stall_out, 0);
    endtask

    initial begin
        //            m       wb     alu           z   f3      stall fault pc  wb
        tbl[0] = '{3'b000, 2'b11, 32'h1234, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 2'b11};
        tbl[1] = '{3'b001, 2'b01, 32'h0,    1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 2'b01};
        tbl[2] = '{3'b001, 2'b01, 32'h5,    1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 2'b01};
        tbl[3] = '{3'b010, 2'b11, 32'h101,  1'b0, 3'b010, 1'b0, 1'b1, 1'b0, 2'b00};
        tbl[4] = '{3'b010, 2'b11, 32'h101,  1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 2'b00};
        tbl[5] = '{3'b100, 2'b11, 32'h102,  1'b0, 3'b010, 1'b0, 1'b1, 1'b0, 2'b00};
        tbl[6] = '{3'b010, 2'b11, 32'h0,    1'b0, 3'b011, 1'b0, 1'b1, 1'b0, 2'b00};
        tbl[7] = '{3'b100, 2'b11, 32'h0,    1'b0, 3'b100, 1'b0, 1'b1, 1'b0, 2'b00};
        tbl[8] = '{3'b110, 2'b11, 32'h0,    1'b0, 3'b010, 1'b0, 1'b1, 1'b0, 2'b00};
        tbl[9] = '{3'b101, 2'b11, 32'h103,  1'b1, 3'b001, 1'b0, 1'b1, 1'b1, 2'b00};

        #2;
        chk("rst req", dmem_req, 0);
        chk("rst stall", stall_out, 0);
        chk("rst fault", fault_out, 0);
        chk("rst data", mem_data_out, 0);
        @(negedge step_clk); reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge step_clk);
            m_in = tbl[i].m; wb_in = tbl[i].wb; alu_result_in = tbl[i].alu;
            alu_zero_in = tbl[i].zero; funct3_in = tbl[i].f3;
            #2;
            chk($sformatf("v%0d stall", i), stall_out, tbl[i].e_stall);
            chk($sformatf("v%0d fault", i), fault_out, tbl[i].e_fault);
            chk($sformatf("v%0d pc_src", i), pc_src_out, tbl[i].e_pc);
            chk($sformatf("v%0d wb", i), wb_out, tbl[i].e_wb);
            chk($sformatf("v%0d req", i), dmem_req, 0);
            chk($sformatf("v%0d data", i), mem_data_out, 0);
            chk($sformatf("v%0d alu", i), alu_result_out, tbl[i].alu);
            chk($sformatf("v%0d wreg", i), write_reg_out, 4'hA);
            chk($sformatf("v%0d btgt", i), branch_target_out, 64'h0123_4567_89AB_CDEF);
        end
        @(negedge step_clk); m_in = 3'b000; alu_zero_in = 1'b0;

        run_op("lw100",  3'b010, 32'h100, 32'h0,      3'b010, 0, 32'hDEADBEEF, 32'h100, 4'b1111, 32'h0, 32'hDEADBEEF);
        run_op("lb103",  3'b010, 32'h103, 32'h0,      3'b000, 0, 32'h80FFFFFF, 32'h100, 4'b1111, 32'h0, 32'hFFFFFF80);
        run_op("lbu103", 3'b010, 32'h103, 32'h0,      3'b100, 0, 32'h80FFFFFF, 32'h100, 4'b1111, 32'h0, 32'h00000080);
        run_op("lh106",  3'b010, 32'h106, 32'h0,      3'b001, 1, 32'h80010000, 32'h104, 4'b1111, 32'h0, 32'hFFFF8001);
        run_op("lhu104", 3'b010, 32'h104, 32'h0,      3'b101, 0, 32'h1234F00D, 32'h104, 4'b1111, 32'h0, 32'h0000F00D);
        run_op("sh102",  3'b100, 32'h102, 32'h0000ABCD, 3'b001, 3, 32'hFFFFFFFF, 32'h100, 4'b1100, 32'hABCDABCD, 32'h0);
        run_op("sb101",  3'b100, 32'h101, 32'h00000077, 3'b000, 0, 32'h0,      32'h100, 4'b0010, 32'h77777777, 32'h0);

        // Timeout: ready never rises; 16 stalled cycles, then an abort cycle with the request still up.
        @(negedge step_clk);
        m_in = 3'b010; alu_result_in = 32'h300; funct3_in = 3'b010; wb_in = 2'b11; dmem_ready = 1'b0;
        #2;
        chk("tmo stall 0", stall_out, 1);
        for (int i = 1; i < 16; i++) begin
            @(negedge step_clk); #2;
            chk($sformatf("tmo stall %0d", i), stall_out, 1);
            chk($sformatf("tmo fault %0d", i), fault_out, 0);
        end
        @(negedge step_clk); #2;
        chk("tmo fault", fault_out, 1);
        chk("tmo stall end", stall_out, 0);
        chk("tmo wb", wb_out, 2'b00);
        chk("tmo req held", dmem_req, 1);
        @(negedge step_clk); m_in = 3'b000; #2;
        chk("tmo req drop", dmem_req, 0);
        chk("tmo fault clear", fault_out, 0);

        // Asynchronous reset in the middle of an access.
        @(negedge step_clk);
        m_in = 3'b010; alu_result_in = 32'h300; funct3_in = 3'b010; dmem_ready = 1'b0;
        @(negedge step_clk); #2;
        chk("mid req", dmem_req, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("arst req", dmem_req, 0);
        chk("arst stall", stall_out, 0);
        chk("arst fault", fault_out, 0);
        chk("arst data", mem_data_out, 0);
        @(negedge step_clk); m_in = 3'b000; reset_n = 1'b1;

        run_op("sw200", 3'b100, 32'h200, 32'hCAFEF00D, 3'b010, 0, 32'h0, 32'h200, 4'b1111, 32'hCAFEF00D, 32'h0);

        @(negedge step_clk);
        m_in = 3'b001; alu_zero_in = 1'b1; #2;
        chk("br taken", pc_src_out, 1);
        chk("br stall", stall_out, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
